// File: rtl/exc_commit_if.sv
// exc_commit_if: memory-stage exception inputs and CP0/pipeline control outputs of exc_commit_ctrl.
interface exc_commit_if;
   logic        exc_valid;
   logic [7:0]  exc_flags;
   logic [31:0] pc;
   logic [31:0] data_addr;
   logic        in_delayslot;
   logic [31:0] status;
   logic [31:0] cause;
   logic [31:0] epc;
   logic        bus_busy;
   logic [31:0] excepttype;
   logic [31:0] commit_pc;
   logic        delayslot;
   logic [31:0] bad_addr;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   modport master (
      output exc_valid, exc_flags, pc, data_addr, in_delayslot, status, cause, epc, bus_busy,
      input  excepttype, commit_pc, delayslot, bad_addr, stall, flush, redirect_valid, redirect_pc
   );
   modport slave (
      input  exc_valid, exc_flags, pc, data_addr, in_delayslot, status, cause, epc, bus_busy,
      output excepttype, commit_pc, delayslot, bad_addr, stall, flush, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl: prioritises exceptions/interrupts, waits for the data bus, pulses excepttype to CP0,
// then flushes the pipeline and redirects fetch to the exception vector or EPC.
module exc_commit_ctrl #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int          FLUSH_CYCLES = 1
) (
   input logic         clk,
   input logic         rst,
   exc_commit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_BUS, COMMIT, FLUSH} state_t;
   state_t      state, next;
   logic [3:0]  code, code_d, cnt;
   logic [31:0] cap_pc, bad, bad_d, last_rpc;
   logic        ds, stall_q, flush_q, int_pend, detect;
   logic [7:0]  f;
   logic        unused;
   assign f        = bus.exc_flags;
   assign int_pend = bus.status[0] & ~bus.status[1] & |(bus.status[15:8] & bus.cause[15:8]);
   assign detect   = state == IDLE && bus.exc_valid && (int_pend || |f);
   assign unused   = ^{bus.status[31:16], bus.status[7:2], bus.cause[31:16], bus.cause[7:0]};
   always_comb begin
      code_d = int_pend ? 4'h1 : f[0] ? 4'h4 : f[1] ? 4'hA : f[2] ? 4'hC : f[3] ? 4'h8 :
               f[4] ? 4'h9 : f[5] ? 4'hE : f[6] ? 4'h4 : f[7] ? 4'h5 : 4'h0;
      // an interrupt or any higher-priority non-address fault masks the bad address
      bad_d  = int_pend ? 32'h0 : f[0] ? bus.pc : |f[5:1] ? 32'h0 :
               |f[7:6] ? bus.data_addr : 32'h0;
      next   = state;
      case (state)
         IDLE:     next = detect ? (bus.bus_busy ? WAIT_BUS : COMMIT) : IDLE;
         WAIT_BUS: next = bus.bus_busy ? WAIT_BUS : COMMIT;
         COMMIT:   next = FLUSH_CYCLES > 0 ? FLUSH : IDLE;
         default:  next = cnt == 4'(FLUSH_CYCLES - 1) ? IDLE : FLUSH;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         code     <= '0;
         cap_pc   <= '0;
         ds       <= 1'b0;
         bad      <= '0;
         stall_q  <= 1'b0;
         flush_q  <= 1'b0;
         last_rpc <= '0;
      end else begin
         state    <= next;
         cnt      <= state == FLUSH ? cnt + 4'd1 : 4'd0;
         stall_q  <= next != IDLE;
         flush_q  <= next == COMMIT || next == FLUSH;
         last_rpc <= bus.redirect_pc;
         if (detect) begin
            code   <= code_d;
            cap_pc <= bus.pc;
            ds     <= bus.in_delayslot;
            bad    <= bad_d;
         end
      end
   end
   assign bus.excepttype     = state == COMMIT ? {28'h0, code} : 32'h0;
   assign bus.redirect_valid = state == COMMIT;
   assign bus.redirect_pc    = state == COMMIT ? (code == 4'hE ? bus.epc : EXC_VECTOR) : last_rpc;
   assign bus.commit_pc      = cap_pc;
   assign bus.delayslot      = ds;
   assign bus.bad_addr       = bad;
   assign bus.stall          = stall_q;
   assign bus.flush          = flush_q;
endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb_exc_commit_ctrl: directed and randomized exception sequences checked against a transaction-level model.
module tb_exc_commit_ctrl;
   localparam logic [31:0] VEC = 32'hBFC00380;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   exc_commit_if ia ();
   exc_commit_if ib ();
   exc_commit_ctrl dut_a (.clk(clk), .rst(rst), .bus(ia));
   exc_commit_ctrl #(.FLUSH_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));
   int passed = 0;
   int total = 0;
   int fails = 0;
   logic [31:0] last_rpc = 32'h0;
   // exception codes indexed by flag bit; flag bits are already in priority order
   logic [3:0] pri_code [8] = '{4'h4, 4'hA, 4'hC, 4'h8, 4'h9, 4'hE, 4'h4, 4'h5};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      ia.exc_valid = 0; ia.exc_flags = 0; ia.pc = 0; ia.data_addr = 0; ia.in_delayslot = 0;
      ia.status = 0; ia.cause = 0; ia.epc = 0; ia.bus_busy = 0;
      ib.exc_valid = 0; ib.exc_flags = 0; ib.pc = 0; ib.data_addr = 0; ib.in_delayslot = 0;
      ib.status = 0; ib.cause = 0; ib.epc = 0; ib.bus_busy = 0;
   endtask

   task automatic run_exc(input logic [7:0] fl, input logic [31:0] pcv, input logic [31:0] da,
                          input logic dsv, input logic [31:0] st, input logic [31:0] ca,
                          input logic [31:0] ep, input int busy_n);
      logic ip;
      int w;
      logic [31:0] ecode, ebad, erpc;
      ip = st[0] & ~st[1] & |(st[15:8] & ca[15:8]);
      w = -1;
      for (int i = 7; i >= 0; i--) if (fl[i]) w = i;
      ecode = ip ? 32'h1 : (w >= 0 ? {28'h0, pri_code[w]} : 32'h0);
      ebad  = ip ? 32'h0 : w == 0 ? pcv : w >= 6 ? da : 32'h0;
      erpc  = (!ip && w == 5) ? ep : VEC;
      ia.exc_valid = 1; ia.exc_flags = fl; ia.pc = pcv; ia.data_addr = da; ia.in_delayslot = dsv;
      ia.status = st; ia.cause = ca; ia.epc = $urandom; ia.bus_busy = busy_n > 0;
      @(posedge clk); #1;
      for (int i = 0; i < busy_n; i++) begin
         ia.exc_flags = 8'($urandom); ia.pc = $urandom; ia.data_addr = $urandom;
         ia.bus_busy = i < busy_n - 1;
         @(negedge clk);
         chk("wait_stall", {31'h0, ia.stall}, 32'h1);
         chk("wait_flush", {31'h0, ia.flush}, 32'h0);
         chk("wait_exctype", ia.excepttype, 32'h0);
         @(posedge clk); #1;
      end
      ia.exc_valid = 0; ia.epc = ep; ia.bus_busy = 1'($urandom);
      @(negedge clk);
      chk("commit_exctype", ia.excepttype, ecode);
      chk("commit_flush", {31'h0, ia.flush}, 32'h1);
      chk("commit_stall", {31'h0, ia.stall}, 32'h1);
      chk("commit_rv", {31'h0, ia.redirect_valid}, 32'h1);
      chk("commit_rpc", ia.redirect_pc, erpc);
      chk("commit_pc", ia.commit_pc, pcv);
      chk("commit_bad", ia.bad_addr, ebad);
      chk("commit_ds", {31'h0, ia.delayslot}, {31'h0, dsv});
      last_rpc = erpc;
      @(posedge clk); #1;
      ia.bus_busy = 1'($urandom);
      @(negedge clk);
      chk("flush_flush", {31'h0, ia.flush}, 32'h1);
      chk("flush_rv", {31'h0, ia.redirect_valid}, 32'h0);
      chk("flush_exctype", ia.excepttype, 32'h0);
      chk("flush_rpc", ia.redirect_pc, last_rpc);
      @(posedge clk); #1;
      ia.bus_busy = 0;
      @(negedge clk);
      chk("idle_stall", {31'h0, ia.stall}, 32'h0);
      chk("idle_flush", {31'h0, ia.flush}, 32'h0);
      chk("idle_rpc", ia.redirect_pc, last_rpc);
   endtask

   initial begin
      int fl_cnt, pulses;
      logic [31:0] seen;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_exctype", ia.excepttype, 32'h0);
      chk("rst_stall", {31'h0, ia.stall}, 32'h0);
      chk("rst_flush", {31'h0, ia.flush}, 32'h0);
      chk("rst_rv", {31'h0, ia.redirect_valid}, 32'h0);
      chk("rst_rpc", ia.redirect_pc, 32'h0);
      chk("rst_pc", ia.commit_pc, 32'h0);
      chk("rst_bad", ia.bad_addr, 32'h0);
      chk("rst_b_flush", {31'h0, ib.flush}, 32'h0);
      run_exc(8'h08, 32'hBFC00100, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0);
      run_exc(8'h80, 32'hBFC00200, 32'h80000003, 0, 32'h0, 32'h0, 32'h0, 3);
      run_exc(8'h04, 32'hBFC00300, 32'h12345678, 0, 32'h0000FF01, 32'h00000400, 32'h0, 0);
      run_exc(8'h04, 32'hBFC00300, 32'h12345678, 0, 32'h0000FF03, 32'h00000400, 32'h0, 0);
      run_exc(8'h01, 32'hBFC00400, 32'h0, 0, 32'h0000FF01, 32'h00000400, 32'h0, 1);
      run_exc(8'h20, 32'hBFC00500, 32'h0, 0, 32'h0, 32'h0, 32'hBFC00704, 0);
      run_exc(8'h20, 32'hBFC00500, 32'h0, 0, 32'h0000FF01, 32'h00000400, 32'hBFC00704, 2);
      run_exc(8'h43, 32'hBFC00002, 32'h80001001, 1, 32'h0, 32'h0, 32'h0, 0);
      for (int n = 0; n < 30; n++) begin
         logic [7:0] fl;
         logic [31:0] st, ca;
         ia.exc_valid = 0; ia.exc_flags = 8'hFF;
         @(posedge clk);
         @(negedge clk);
         chk("novalid_stall", {31'h0, ia.stall}, 32'h0);
         st = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
         ca = {16'h0, 8'($urandom), 8'h0};
         fl = 8'($urandom);
         if (fl == 0) fl = 8'(1 << $urandom_range(7, 0));
         run_exc(fl, $urandom, $urandom, 1'($urandom), st, ca, $urandom, $urandom_range(0, 3));
      end
      ia.exc_valid = 1; ia.exc_flags = 8'h80; ia.bus_busy = 1;
      @(posedge clk); #1;
      ia.exc_valid = 0;
      @(negedge clk);
      chk("pre_rst_stall", {31'h0, ia.stall}, 32'h1);
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("post_rst_stall", {31'h0, ia.stall}, 32'h0);
      chk("post_rst_rpc", ia.redirect_pc, 32'h0);
      pulses = 0;
      ia.bus_busy = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ia.excepttype != 0 || ia.flush) pulses++;
      end
      chk("post_rst_pulses", pulses, 0);
      ib.exc_valid = 1; ib.exc_flags = 8'h08;
      @(posedge clk); #1;
      ib.exc_valid = 0; ib.exc_flags = 0;
      fl_cnt = 0; pulses = 0; seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ib.flush) fl_cnt++;
         if (ib.excepttype != 0) begin
            pulses++;
            seen = ib.excepttype;
         end
      end
      chk("b_flush_cycles", fl_cnt, 4);
      chk("b_pulses", pulses, 1);
      chk("b_code", seen, 32'h8);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
